// File: rtl/aes_inv_keysched_seq.sv
// aes_inv_keysched_seq
// ---------------------------------------------------------------------------
// Sequential AES key expander for the decryption datapath. A 128/192/256-bit
// cipher key is expanded one 32-bit word per cycle into a 60-word register
// file. The round keys are then streamed in reverse order (round Nr down to
// round 0) over a valid/ready handshake.
//
// Optional feature macro: AES_EQINV_KEY_EN
//   When defined, rounds 1..Nr-1 are passed through InvMixColumns on the read
//   side (FIPS-197 equivalent inverse cipher). Rounds Nr and 0 stay raw.
//
// Ports:
//   clk        in   1    sole clock, rising edge
//   reset      in   1    synchronous active-high reset
//   start      in   1    begin expansion (sampled only in IDLE)
//   mode       in   2    00 AES-128, 01 AES-192, 10 AES-256, 11 reserved
//   key_in     in   256  cipher key, left-aligned
//   busy       out  1    high while expanding or serving keys
//   rk_valid   out  1    round_key is valid
//   rk_ready   in   1    consumer accepts the current key
//   round_key  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, 0 when not valid
//   rk_round   out  4    current round index r (0 when not valid)
//   rk_last    out  1    high with rk_valid when r == 0
//
// Handshake: a key transfers on a rising edge where rk_valid & rk_ready are
// both high. While rk_valid is high and rk_ready is low, round_key, rk_round
// and rk_last hold stable. rk_valid never depends on rk_ready, and no output
// has a combinational path from rk_ready.
// ---------------------------------------------------------------------------
module aes_inv_keysched_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_SERVE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  mode_q;
  logic [5:0]  idx;        // index i of the word being produced
  logic [2:0]  phase;      // i mod Nk, tracked incrementally
  logic [7:0]  rcon;       // Rcon[i/Nk] for the next Nk boundary
  logic [3:0]  rnd;        // round currently offered
  logic [31:0] rf [0:59];  // expanded key words w[0..T-1]

  // Per-mode constants for the latched mode
  logic [5:0]  nk;
  logic [2:0]  nk_last;    // Nk-1, the phase value that wraps to 0
  logic [3:0]  nr;
  logic [5:0]  last_idx;   // T-1
  logic [5:0]  start_nk;   // Nk for the mode presented with start
  logic        start_ok;

  // Expansion datapath
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] tmix;
  logic [31:0] w_new;

  logic [127:0] raw_key;
  logic [127:0] key_sel;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] b;
    acc = 8'h00;
    b   = x;
    for (int n = 0; n < 8; n++) begin
      if (y[n]) acc = acc ^ b;
      b = xtime(b);
    end
    return acc;
  endfunction

  // Forward S-box: multiplicative inverse in GF(2^8) (x^254) followed by the
  // affine transform. Inverse of 0 maps to 0 naturally through x^254.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    nk       = 6'd8;
    nk_last  = 3'd7;
    nr       = 4'd14;
    last_idx = 6'd59;
    case (mode_q)
      2'b00: begin
        nk       = 6'd4;
        nk_last  = 3'd3;
        nr       = 4'd10;
        last_idx = 6'd43;
      end
      2'b01: begin
        nk       = 6'd6;
        nk_last  = 3'd5;
        nr       = 4'd12;
        last_idx = 6'd51;
      end
      default: begin
      end
    endcase
  end

  assign start_ok = start && (mode != 2'b11);
  assign start_nk = (mode == 2'b00) ? 6'd4 : ((mode == 2'b01) ? 6'd6 : 6'd8);

  // ------------------------------------------------------------------------
  // Word generator: w[i] = w[i-Nk] ^ t
  // ------------------------------------------------------------------------
  always_comb begin
    w_prev  = rf[idx - 6'd1];
    w_back  = rf[idx - nk];
    sub_in  = (phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
               sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    tmix    = w_prev;
    if (phase == 3'd0) begin
      tmix = sub_out ^ {rcon, 24'h000000};
    end else if ((nk == 6'd8) && (phase == 3'd4)) begin
      tmix = sub_out;
    end
    w_new   = w_back ^ tmix;
  end

  // ------------------------------------------------------------------------
  // FSM next state
  // ------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_ok) state_nxt = S_EXPAND;
      S_EXPAND: if (idx == last_idx) state_nxt = S_SERVE;
      S_SERVE:  if (rk_ready && (rnd == 4'd0)) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // State and control registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      mode_q <= 2'b00;
      idx    <= 6'd0;
      phase  <= 3'd0;
      rcon   <= 8'h01;
      rnd    <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            mode_q <= mode;
            idx    <= start_nk;
            phase  <= 3'd0;
            rcon   <= 8'h01;
          end
        end
        S_EXPAND: begin
          idx   <= idx + 6'd1;
          phase <= (phase == nk_last) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rcon <= xtime(rcon);
          if (idx == last_idx) rnd <= nr;
        end
        S_SERVE: begin
          if (rk_ready && (rnd != 4'd0)) rnd <= rnd - 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Register file. Not reset: contents are only visible through the masked
  // round_key output. All eight key words are loaded on start regardless of
  // Nk; any beyond Nk are overwritten by the expansion before being read.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((state == S_IDLE) && start_ok) begin
        rf[0] <= key_in[255:224];
        rf[1] <= key_in[223:192];
        rf[2] <= key_in[191:160];
        rf[3] <= key_in[159:128];
        rf[4] <= key_in[127:96];
        rf[5] <= key_in[95:64];
        rf[6] <= key_in[63:32];
        rf[7] <= key_in[31:0];
      end else if (state == S_EXPAND) begin
        rf[idx] <= w_new;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Read side
  // ------------------------------------------------------------------------
  assign raw_key = {rf[{rnd, 2'b00}], rf[{rnd, 2'b01}],
                    rf[{rnd, 2'b10}], rf[{rnd, 2'b11}]};

`ifdef AES_EQINV_KEY_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  always_comb begin
    key_sel = raw_key;
    if ((rnd != 4'd0) && (rnd != nr)) begin
      key_sel = {inv_mix_col(raw_key[127:96]), inv_mix_col(raw_key[95:64]),
                 inv_mix_col(raw_key[63:32]),  inv_mix_col(raw_key[31:0])};
    end
  end
`else
  assign key_sel = raw_key;
`endif

  assign busy      = (state != S_IDLE);
  assign rk_valid  = (state == S_SERVE);
  assign round_key = rk_valid ? key_sel : 128'd0;
  assign rk_round  = rk_valid ? rnd : 4'd0;
  assign rk_last   = rk_valid && (rnd == 4'd0);

endmodule

// File: tb/tb_aes_inv_keysched_seq.sv
// tb_aes_inv_keysched_seq
// ---------------------------------------------------------------------------
// Self-checking bench for aes_inv_keysched_seq. A reference key expansion
// (with its own S-box generator) pushes the expected reverse-order stream into
// a queue on every accepted start; transfers pop and compare. A vector table
// covers the three key sizes with known first round keys and latencies; hand
// sequences cover backpressure, ignored starts, reserved mode and reset.
// Honors AES_EQINV_KEY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_aes_inv_keysched_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   rk_round;
  logic         rk_last;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  aes_inv_keysched_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .rk_round  (rk_round),
    .rk_last   (rk_last)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [132:0] exp_q[$];   // {last, round, key}
  logic [7:0]   sbox_tab [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // S-box via the p/q generator walk (independent of the design's x^254 form)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_EQINV_KEY_EN
  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    for (int k = 0; k < 4; k++) begin
      logic [7:0] x2, x4, x8;
      a[k] = c[31-8*k -: 8];
      x2 = xt(a[k]);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  // Reference expansion; pushes rounds Nr..0 onto the expected queue
  task automatic push_stream(input logic [1:0] m, input logic [255:0] key);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] rk;
    int nk, nr, tot;
    nk  = (m == 2'b00) ? 4 : ((m == 2'b01) ? 6 : 8);
    nr  = nk + 6;
    tot = 4 * (nr + 1);
    for (int k = 0; k < nk; k++) w[k] = key[255-32*k -: 32];
    rc = 8'h01;
    for (int i = nk; i < tot; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = nr; r >= 0; r--) begin
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
`ifdef AES_EQINV_KEY_EN
      if (r != 0 && r != nr)
        rk = {imc_col(rk[127:96]), imc_col(rk[95:64]), imc_col(rk[63:32]), imc_col(rk[31:0])};
`endif
      exp_q.push_back({(r == 0), 4'(r), rk});
    end
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge (cycle 0); returns in cycle 1.
  task automatic do_start(input logic [1:0] m, input logic [255:0] key);
    start  = 1'b1;
    mode   = m;
    key_in = key;
    push_stream(m, key);
    @(posedge clk); #1;
    start  = 1'b0;
    mode   = 2'($urandom_range(3));
    key_in = rand_key();
  endtask

  // Counts the cycle index at which rk_valid is first seen, starting at c0.
  task automatic wait_valid(output int lat, input int c0, input int budget);
    lat = c0;
    while (!rk_valid && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Drains the expected queue. ready_pct: chance of rk_ready per cycle.
  // pulse_at: cycle (relative) at which a stray start is driven, -1 for none.
  task automatic serve_stream(input int ready_pct, input int pulse_at, input int budget);
    int           n;
    bit           stalled;
    logic [127:0] s_key;
    logic [3:0]   s_rnd;
    logic         s_last;
    logic [132:0] e;
    n = 0;
    stalled = 1'b0;
    while (exp_q.size() > 0 && n < budget) begin
      if (stalled) begin
        check("stall_valid", 128'(rk_valid), 128'(1'b1));
        check("stall_key", round_key, s_key);
        check("stall_round", 128'(rk_round), 128'(s_rnd));
        check("stall_last", 128'(rk_last), 128'(s_last));
      end
      start = (n == pulse_at);
      if (start) begin
        mode   = 2'b10;
        key_in = rand_key();
      end
      rk_ready = ($urandom_range(99) < ready_pct);
      stalled  = 1'b0;
      if (rk_valid && rk_ready) begin
        e = exp_q.pop_front();
        check("rk_key", round_key, e[127:0]);
        check("rk_round", 128'(rk_round), 128'(e[131:128]));
        check("rk_last", 128'(rk_last), 128'(e[132]));
      end else if (rk_valid) begin
        stalled = 1'b1;
        s_key   = round_key;
        s_rnd   = rk_round;
        s_last  = rk_last;
      end
      @(posedge clk); #1;
      n++;
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: actual %0d keys left required 0", exp_q.size());
      exp_q.delete();
    end else begin
      check("busy_fall", 128'(busy), 128'(1'b0));
      check("valid_fall", 128'(rk_valid), 128'(1'b0));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(1'b0));
    check({tag, "_valid"}, 128'(rk_valid), 128'(1'b0));
    check({tag, "_key"}, round_key, 128'd0);
    check({tag, "_round"}, 128'(rk_round), 128'd0);
    check({tag, "_last"}, 128'(rk_last), 128'd0);
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    logic [127:0] rk_first;
    logic [3:0]   nr;
    int           lat;
  } vec_t;

  vec_t vecs [3];

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    int lat;

    vecs[0] = '{mode: 2'b00, key: KEY128,
                rk_first: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, nr: 4'd10, lat: 41};
    vecs[1] = '{mode: 2'b01, key: {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                rk_first: 128'he98ba06f448c773c8ecc720401002202, nr: 4'd12, lat: 47};
    vecs[2] = '{mode: 2'b10, key: KEY256,
                rk_first: 128'hfe4890d1e6188d0b046df344706c631e, nr: 4'd14, lat: 53};

    build_sbox();
    reset    = 1'b1;
    start    = 1'b0;
    mode     = 2'b00;
    key_in   = '0;
    rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Known-answer vectors, back to back: each start lands in the cycle busy falls
    for (int v = 0; v < 3; v++) begin
      do_start(vecs[v].mode, vecs[v].key);
      check("busy_rise", 128'(busy), 128'(1'b1));
      wait_valid(lat, 1, 200);
      check("first_latency", 128'(lat), 128'(vecs[v].lat));
      check("first_key", round_key, vecs[v].rk_first);
      check("first_round", 128'(rk_round), 128'(vecs[v].nr));
      serve_stream(100, -1, 100);
    end

    // Stray start during EXPAND (cycle 10), then random backpressure with a
    // stray start during SERVE.
    do_start(2'b00, KEY128);
    repeat (9) begin
      @(posedge clk); #1;
    end
    start  = 1'b1;
    mode   = 2'b01;
    key_in = rand_key();
    @(posedge clk); #1;
    start  = 1'b0;
    wait_valid(lat, 11, 200);
    check("expand_start_latency", 128'(lat), 128'd41);
    serve_stream(30, 3, 400);

    // Random AES-192 key with backpressure
    do_start(2'b01, rand_key());
    wait_valid(lat, 1, 200);
    check("rand192_latency", 128'(lat), 128'd47);
    serve_stream(30, -1, 400);

    // Reserved mode is ignored
    start  = 1'b1;
    mode   = 2'b11;
    key_in = rand_key();
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("mode11_busy", 128'(busy), 128'(1'b0));
      check("mode11_valid", 128'(rk_valid), 128'(1'b0));
      @(posedge clk); #1;
    end

    // Reset in cycle 20 of an AES-256 expansion
    do_start(2'b10, KEY256);
    repeat (19) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_busy", 128'(busy), 128'(1'b0));

    // Fresh AES-128 run after reset
    do_start(2'b00, KEY128);
    wait_valid(lat, 1, 200);
    check("after_reset_latency", 128'(lat), 128'd41);
    check("after_reset_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    serve_stream(100, -1, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_keysched_seq.md
# aes_inv_keysched_seq

Sequential AES key expander that feeds the decryption datapath. It expands a 128/192/256-bit cipher key one 32-bit word per cycle into an internal 60-word register file. It then streams round keys in reverse order (round Nr down to round 0) over a valid/ready handshake. It is the decrypt-side counterpart of the combinational forward round-key generator and uses the same mode encoding and key alignment.

## Interface
Parameters: none. Nr and Nk are derived from `mode`.

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  begin expansion; sampled only in IDLE
- `mode`  in  2  00 AES-128, 01 AES-192, 10 AES-256, 11 reserved; latched on accepted `start`
- `key_in`  in  256  cipher key, left-aligned:
  - AES-128 uses [255:128]
  - AES-192 uses [255:64]
  - AES-256 uses [255:0]
- `busy`  out  1  high in EXPAND and SERVE
- `rk_valid`  out  1  `round_key` is valid
- `rk_ready`  in  1  consumer accepts the key
- `round_key`  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]} for the current round r; 0 when `rk_valid` is low
- `rk_round`  out  4  current round index r
- `rk_last`  out  1  high with `rk_valid` when r == 0

## Operation
- Derived values:
  - Nk = 4/6/8 and Nr = 10/12/14.
  - Total words T = 4(Nr+1) = 44/52/60.
  - Word count W = T − Nk = 40/46/52.
- IDLE:
  - `start` with mode ≠ 11: latch mode, write w[0..Nk−1] from the top Nk words of `key_in`, set i = Nk, go to EXPAND.
  - `start` with mode 11 is ignored.
- EXPAND: each cycle computes one word w[i] = w[i−Nk] ^ t, where t is:
  - SubWord(RotWord(w[i−1])) ^ Rcon[i/Nk] when i mod Nk == 0
  - SubWord(w[i−1]) when Nk == 8 and i mod 8 == 4
  - w[i−1] otherwise
- EXPAND hardware:
  - SubWord uses four instances of the team's forward S-box.
  - Rcon advances 01, 02, 04 … 80, 1b, 36 via xtime, once per Nk-boundary.
  - When i == T−1 has been written: set r = Nr, go to SERVE.
- SERVE:
  - `rk_valid` = 1.
  - On `rk_valid & rk_ready` with r > 0: r ← r−1.
  - On `rk_valid & rk_ready` with r == 0: go to IDLE.
- Handshake: while `rk_valid` is high and `rk_ready` is low, `round_key`, `rk_round` and `rk_last` hold stable.
- `start` outside IDLE is ignored; an expansion cannot be restarted mid-stream.
- Reset mid-operation:
  - Next cycle: IDLE, with all outputs at reset values.
  - Register-file contents are not cleared and are never exposed, because `round_key` is masked when `rk_valid` is low.
- Arithmetic: all word operations are 32-bit XOR. Index i is 6 bits; r is 4 bits.

## Timing
- Reset values: `busy` 0, `rk_valid` 0, `round_key` 0, `rk_round` 0, `rk_last` 0; state IDLE.
- Expansion: with `start` in cycle 0, EXPAND occupies cycles 1..W and `rk_valid` first rises in cycle W+1:
  - AES-128: cycle 41
  - AES-192: cycle 47
  - AES-256: cycle 53
- Throughput: one key per cycle when `rk_ready` is held high, so the full stream takes Nr+1 cycles.
- End of stream: `busy` falls the cycle after the round-0 transfer, and a new `start` is accepted that same cycle.
- `busy` rises in cycle 1.
- All outputs are registered or derived from registered state only; there is no combinational path from `rk_ready` to `round_key`.

## Configuration
- `AES_EQINV_KEY_EN` defined:
  - For rounds 1..Nr−1, `round_key` is InvMixColumns applied to the stored key, as required by the FIPS-197 equivalent inverse cipher.
  - Rounds Nr and 0 are output unmodified.
  - The transform is combinational on the register-file read; latency is unchanged.
- Not defined: raw expanded keys are output for all rounds, and no InvMixColumns logic is instantiated.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, start, `rk_ready`=1:
  - cycle 41: `rk_round`=10, `round_key`=d014f9a8c9ee2589e13f0cc8b6630ca6
  - final key: round 0 = 2b7e…4f3c with `rk_last`=1
  - `busy` low one cycle later
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - cycle 47: `rk_round`=12, `round_key`=e98ba06f448c773c8ecc720401002202
  - 13 keys total, each matching the software model
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - cycle 53: `rk_round`=14, `round_key`=fe4890d1e6188d0b046df344706c631e
  - round 13 = 1f352c07…dff4 ^ …, checked against the model
- Backpressure: random `rk_ready` (about 30% high) → outputs stable while stalled; no key skipped or duplicated; order 10..0.
- Ignored inputs:
  - `start` pulsed during EXPAND and during SERVE → no effect on the stream.
  - `start` with mode 11 in IDLE → `busy` stays 0.
- Reset:
  - `reset` at cycle 20 of an AES-256 expansion → cycle 21 all outputs 0.
  - A fresh AES-128 start then produces the correct stream.
  - With `AES_EQINV_KEY_EN` defined: rounds 1..9 match InvMixColumns(model key), and rounds 10 and 0 are raw.
